// File: rtl/gate_arbiter.sv
// Single-lane barrier controller shared by entry and exit traffic.
// Arbitrates entry/exit requests, refuses entry when the lot is full and
// exit when it is empty, and sequences the barrier through open, pass and
// close phases with a saturating down-counter timer.
module gate_arbiter #(
    parameter int CAPACITY       = 7,
    parameter int MOVE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_in,
    input  logic       req_out,
    input  logic       pass_in,
    input  logic       pass_out,
    input  logic [2:0] count,
    output logic       gate_open,
    output logic       grant_in,
    output logic       grant_out,
    output logic       busy,
    output logic       full,
    output logic       reject_in,
    output logic       reject_out,
    output logic       timeout
);

    localparam int TMAX = (MOVE_CYCLES > TIMEOUT_CYCLES) ? MOVE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] MOVE_LOAD    = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    CAP3         = 3'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        PASSING,
        CLOSING
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic            pend_in_reg;
    logic            pend_out_reg;
    logic            last_in_reg;      // 1 = last service was entry, 0 = exit
    logic            gate_open_reg;
    logic            grant_in_reg;
    logic            grant_out_reg;
    logic            busy_reg;
    logic            reject_in_reg;
    logic            reject_out_reg;
    logic            timeout_reg;

    logic            eff_in;
    logic            eff_out;
    logic            rej_in_next;
    logic            rej_out_next;
    logic            elig_in;
    logic            elig_out;
    logic            pick_in;
    logic            pick_out;
    logic            pass_match;

    // Admission decision for the current IDLE cycle; ties go to the direction not served last
    always_comb begin
        full         = (count >= CAP3);
        eff_in       = pend_in_reg | req_in;
        eff_out      = pend_out_reg | req_out;
        rej_in_next  = eff_in & full;
        rej_out_next = eff_out & (count == 3'd0);
        elig_in      = eff_in & ~full;
        elig_out     = eff_out & (count != 3'd0);
        pick_in      = elig_in & (~elig_out | ~last_in_reg);
        pick_out     = elig_out & ~pick_in;
        pass_match   = (grant_in_reg & pass_in) | (grant_out_reg & pass_out);
    end

    // Barrier sequencer with pending-request latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            pend_in_reg    <= 1'b0;
            pend_out_reg   <= 1'b0;
            last_in_reg    <= 1'b0;
            gate_open_reg  <= 1'b0;
            grant_in_reg   <= 1'b0;
            grant_out_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            reject_in_reg  <= 1'b0;
            reject_out_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            reject_in_reg  <= 1'b0;
            reject_out_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            // Requests are latched in any state; depth is one per direction
            pend_in_reg    <= pend_in_reg | req_in;
            pend_out_reg   <= pend_out_reg | req_out;

            case (state_reg)
                IDLE: begin
                    reject_in_reg  <= rej_in_next;
                    reject_out_reg <= rej_out_next;
                    if (rej_in_next || pick_in) begin
                        pend_in_reg <= 1'b0;
                    end
                    if (rej_out_next || pick_out) begin
                        pend_out_reg <= 1'b0;
                    end
                    if (pick_in || pick_out) begin
                        state_reg     <= OPENING;
                        grant_in_reg  <= pick_in;
                        grant_out_reg <= pick_out;
                        gate_open_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        timer_reg     <= MOVE_LOAD;
                    end
                end

                OPENING: begin
                    if (timer_reg == '0) begin
                        state_reg <= PASSING;
                        timer_reg <= TIMEOUT_LOAD;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                PASSING: begin
                    // A pass on the expiry cycle wins over the timeout
                    if (pass_match) begin
                        state_reg     <= CLOSING;
                        gate_open_reg <= 1'b0;
                        timer_reg     <= MOVE_LOAD;
                    end else if (timer_reg == '0) begin
                        state_reg     <= CLOSING;
                        gate_open_reg <= 1'b0;
                        timeout_reg   <= 1'b1;
                        timer_reg     <= MOVE_LOAD;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                CLOSING: begin
                    if (timer_reg == '0) begin
                        state_reg     <= IDLE;
                        last_in_reg   <= grant_in_reg;
                        grant_in_reg  <= 1'b0;
                        grant_out_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    gate_open_reg <= 1'b0;
                    grant_in_reg  <= 1'b0;
                    grant_out_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign gate_open  = gate_open_reg;
    assign grant_in   = grant_in_reg;
    assign grant_out  = grant_out_reg;
    assign busy       = busy_reg;
    assign reject_in  = reject_in_reg;
    assign reject_out = reject_out_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: stimulus pushes expected output events
// (with the cycle they must appear in) into a queue; a negedge monitor detects
// events on the DUT outputs and pops/compares them in order.
module tb_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_in = 1'b0;
    logic       req_out = 1'b0;
    logic       pass_in = 1'b0;
    logic       pass_out = 1'b0;
    logic [2:0] count = 3'd0;
    logic       gate_open;
    logic       grant_in;
    logic       grant_out;
    logic       busy;
    logic       full;
    logic       reject_in;
    logic       reject_out;
    logic       timeout;

    gate_arbiter #(
        .CAPACITY       (7),
        .MOVE_CYCLES    (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (req_in),
        .req_out    (req_out),
        .pass_in    (pass_in),
        .pass_out   (pass_out),
        .count      (count),
        .gate_open  (gate_open),
        .grant_in   (grant_in),
        .grant_out  (grant_out),
        .busy       (busy),
        .full       (full),
        .reject_in  (reject_in),
        .reject_out (reject_out),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Event kinds, listed in the order the monitor reports same-cycle events
    localparam int EV_REJ_IN    = 0;
    localparam int EV_REJ_OUT   = 1;
    localparam int EV_TIMEOUT   = 2;
    localparam int EV_GATE_FALL = 3;
    localparam int EV_GI_FALL   = 4;
    localparam int EV_GO_FALL   = 5;
    localparam int EV_GI_RISE   = 6;
    localparam int EV_GO_RISE   = 7;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_REJ_IN:    return "reject_in";
            EV_REJ_OUT:   return "reject_out";
            EV_TIMEOUT:   return "timeout";
            EV_GATE_FALL: return "gate_fall";
            EV_GI_FALL:   return "grant_in_fall";
            EV_GO_FALL:   return "grant_out_fall";
            EV_GI_RISE:   return "grant_in_rise";
            EV_GO_RISE:   return "grant_out_rise";
            default:      return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Compare an observed event against the head of the scoreboard
    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s at cycle %0d, want none", ev_name(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_order: got %s at cycle %0d, want %s at cycle %0d",
                         ev_name(kind), cyc, ev_name(e.kind), e.cyc);
            end else begin
                $display("ok   %s at cycle %0d", ev_name(kind), cyc);
            end
        end
    endtask

    logic prev_gate = 1'b0;
    logic prev_gi = 1'b0;
    logic prev_go = 1'b0;

    // Monitor: detect output events away from the active edge
    always @(negedge clk) begin
        if (reject_in)              observe(EV_REJ_IN);
        if (reject_out)             observe(EV_REJ_OUT);
        if (timeout)                observe(EV_TIMEOUT);
        if (prev_gate && !gate_open) observe(EV_GATE_FALL);
        if (prev_gi && !grant_in)   observe(EV_GI_FALL);
        if (prev_go && !grant_out)  observe(EV_GO_FALL);
        if (!prev_gi && grant_in) begin
            observe(EV_GI_RISE);
            check_bit("gate_open_with_grant_in", gate_open, 1'b1);
        end
        if (!prev_go && grant_out) begin
            observe(EV_GO_RISE);
            check_bit("gate_open_with_grant_out", gate_open, 1'b1);
        end
        check_bit("grants_exclusive", grant_in & grant_out, 1'b0);
        check_bit("busy_matches_grant", busy, grant_in | grant_out);
        prev_gate = gate_open;
        prev_gi   = grant_in;
        prev_go   = grant_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one cycle of input pulses, then return them low
    task automatic drive(input logic ri, input logic ro, input logic pi, input logic po);
        req_in   = ri;
        req_out  = ro;
        pass_in  = pi;
        pass_out = po;
        tick();
        req_in   = 1'b0;
        req_out  = 1'b0;
        pass_in  = 1'b0;
        pass_out = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
    endtask

    int c;

    initial begin
        // Reset state
        idle(3);
        reset = 1'b1;
        idle(2);
        check_bit("rst_gate_open", gate_open, 1'b0);
        check_bit("rst_grant_in", grant_in, 1'b0);
        check_bit("rst_grant_out", grant_out, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_reject_in", reject_in, 1'b0);
        check_bit("rst_reject_out", reject_out, 1'b0);
        check_bit("rst_timeout", timeout, 1'b0);

        // Combinational full flag at the capacity boundary
        count = 3'd6;
        #1;
        check_bit("full_at_6", full, 1'b0);
        count = 3'd7;
        #1;
        check_bit("full_at_7", full, 1'b1);
        count = 3'd0;
        #1;

        // T1: single entry, pass after 10 cycles
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_GATE_FALL, c + 11);
        expect_ev(EV_GI_FALL, c + 15);
        drive(1, 0, 0, 0);
        idle(9);
        drive(0, 0, 1, 0);
        idle(8);

        // T2: simultaneous requests with last_served = exit -> entry first
        apply_reset();
        count = 3'd3;
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_GATE_FALL, c + 7);
        expect_ev(EV_GI_FALL, c + 11);
        expect_ev(EV_GO_RISE, c + 12);
        expect_ev(EV_GATE_FALL, c + 18);
        expect_ev(EV_GO_FALL, c + 22);
        drive(1, 1, 0, 0);
        idle(5);
        drive(0, 0, 1, 0);
        idle(10);
        drive(0, 0, 0, 1);
        idle(8);

        // T3: rejects when full / empty, and a reject alongside a grant
        count = 3'd7;
        c = cyc;
        expect_ev(EV_REJ_IN, c + 1);
        expect_ev(EV_REJ_OUT, c + 4);
        expect_ev(EV_REJ_IN, c + 7);
        expect_ev(EV_GO_RISE, c + 7);
        expect_ev(EV_GATE_FALL, c + 13);
        expect_ev(EV_GO_FALL, c + 17);
        drive(1, 0, 0, 0);
        idle(2);
        count = 3'd0;
        drive(0, 1, 0, 0);
        idle(2);
        count = 3'd7;
        drive(1, 1, 0, 0);
        idle(5);
        drive(0, 0, 0, 1);
        idle(8);

        // T4: pass window expiry; wrong-direction pass ignored
        count = 3'd2;
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_TIMEOUT, c + 69);
        expect_ev(EV_GATE_FALL, c + 69);
        expect_ev(EV_GI_FALL, c + 73);
        drive(1, 0, 0, 0);
        idle(19);
        drive(0, 0, 0, 1);
        idle(65);

        // T5: pass on the final window cycle closes without timeout
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_GATE_FALL, c + 69);
        expect_ev(EV_GI_FALL, c + 73);
        drive(1, 0, 0, 0);
        idle(67);
        drive(0, 0, 1, 0);
        idle(8);

        // T6: three exit requests during an entry service -> one exit service
        count = 3'd3;
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_GATE_FALL, c + 7);
        expect_ev(EV_GI_FALL, c + 11);
        expect_ev(EV_GO_RISE, c + 12);
        expect_ev(EV_GATE_FALL, c + 18);
        expect_ev(EV_GO_FALL, c + 22);
        drive(1, 0, 0, 0);
        idle(1);
        drive(0, 1, 0, 0);
        idle(1);
        drive(0, 1, 0, 0);
        idle(1);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        idle(9);
        drive(0, 0, 0, 1);
        idle(15);

        // T7: asynchronous reset during PASSING drops everything, pending exit lost
        c = cyc;
        expect_ev(EV_GI_RISE, c + 1);
        expect_ev(EV_GATE_FALL, c + 8);
        expect_ev(EV_GI_FALL, c + 8);
        drive(1, 0, 0, 0);
        idle(5);
        drive(0, 1, 0, 0);
        idle(1);
        #1;
        reset = 1'b0;
        #1;
        check_bit("async_gate_open", gate_open, 1'b0);
        check_bit("async_grant_in", grant_in, 1'b0);
        check_bit("async_busy", busy, 1'b0);
        idle(2);
        reset = 1'b1;
        idle(20);

        // Every expected event must have been observed
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d events outstanding, want 0 (next %s at cycle %0d)",
                     exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
